// File: rtl/bsg_reg_bank.sv
// Register bank on a valid/ready bus: one control register plus NUM_DATA data registers.
// Define BSG_REG_BANK_STICKY_EN to make status bits sticky (W1C) and drive irq.
module bsg_reg_bank #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned NUM_DATA     = 2,
  parameter int unsigned BASE_ADDR    = 'h10,
  parameter int unsigned CTRL_RW_BITS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid,
  input  logic                             write,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [DATA_W-1:0]                wdata,
  output logic                             ready,
  output logic [DATA_W-1:0]                rdata,
  output logic                             err,
  input  logic [DATA_W-CTRL_RW_BITS-1:0]   status_in,
  output logic [CTRL_RW_BITS-1:0]          ctrl_out,
  output logic [NUM_DATA*DATA_W-1:0]       data_out,
  output logic [NUM_DATA-1:0]              wr_strobe,
  output logic                             irq
);

  localparam int unsigned       SW           = DATA_W - CTRL_RW_BITS;
  localparam logic [ADDR_W-1:0] LP_CTRL_ADDR = ADDR_W'(BASE_ADDR);

  generate
    if (NUM_DATA < 1 || NUM_DATA > 16) begin : g_bad_num_data
      $error("bsg_reg_bank: NUM_DATA must be in 1..16");
    end
    if (CTRL_RW_BITS < 1 || CTRL_RW_BITS >= DATA_W) begin : g_bad_ctrl_bits
      $error("bsg_reg_bank: CTRL_RW_BITS must be in 1..DATA_W-1");
    end
    if ((64'(BASE_ADDR) + 64'(NUM_DATA)) >= (64'd1 << ADDR_W)) begin : g_bad_addr_map
      $error("bsg_reg_bank: BASE_ADDR+NUM_DATA does not fit in ADDR_W bits");
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [CTRL_RW_BITS-1:0] r_ctrl;
  logic [SW-1:0]           r_status;
  logic [SW-1:0]           w_status_next;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_err;
  logic [NUM_DATA-1:0]     r_strobe;
  logic [NUM_DATA-1:0]     w_sel;
  logic                    w_is_ctrl;
  logic                    w_hit;
  logic                    w_commit;
  logic                    w_wr;
  logic [DATA_W-1:0]       w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (valid) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Accesses commit on the accepting edge, so RESP only presents results.
  assign w_commit  = (r_state == IDLE) && valid;
  assign w_wr      = w_commit && write;
  assign w_is_ctrl = (addr == LP_CTRL_ADDR);
  assign w_hit     = w_is_ctrl || (|w_sel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DATA; gi++) begin : g_data
      localparam logic [ADDR_W-1:0] LP_ADDR = ADDR_W'(BASE_ADDR + 1 + gi);
      logic [DATA_W-1:0] r_q;

      assign w_sel[gi] = (addr == LP_ADDR);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_wr && w_sel[gi]) begin
          r_q <= wdata;
        end
      end

      assign data_out[gi*DATA_W +: DATA_W] = r_q;
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      if (w_sel[i]) w_rd_data = data_out[i*DATA_W +: DATA_W];
    end
    if (w_is_ctrl) w_rd_data = {r_status, r_ctrl};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_wr && w_is_ctrl) begin
      r_ctrl <= wdata[CTRL_RW_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= w_status_next;
    end
  end

`ifdef BSG_REG_BANK_STICKY_EN
  logic [SW-1:0] w_w1c;
  logic          r_irq;

  // New status events take priority over a simultaneous W1C.
  assign w_w1c         = (w_wr && w_is_ctrl) ? wdata[DATA_W-1:CTRL_RW_BITS] : '0;
  assign w_status_next = (r_status & ~w_w1c) | status_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_status_next;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_wdata;

  assign w_unused_wdata = ^wdata[DATA_W-1:CTRL_RW_BITS];
  assign w_status_next  = status_in;
  assign irq            = 1'b0;
`endif

  // Writes and misses return zero; response registers clear outside RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_strobe <= '0;
    end else if (w_commit) begin
      r_rdata  <= (write || !w_hit) ? '0 : w_rd_data;
      r_err    <= !w_hit;
      r_strobe <= write ? w_sel : '0;
    end else begin
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_strobe <= '0;
    end
  end

  assign ready     = (r_state == RESP);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign ctrl_out  = r_ctrl;
  assign wr_strobe = r_strobe;

endmodule

// File: tb/tb_bsg_reg_bank.sv
// Scoreboard bench for bsg_reg_bank: stimulus queues expected responses, a monitor checks each ready pulse.
module tb_bsg_reg_bank;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic        ready;
  logic [7:0]  rdata;
  logic        err;
  logic [4:0]  status_in = 5'b00000;
  logic [2:0]  ctrl_out;
  logic [15:0] data_out;
  logic [1:0]  wr_strobe;
  logic        irq;

`ifdef BSG_REG_BANK_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  bsg_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .write(write), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .status_in(status_in),
    .ctrl_out(ctrl_out), .data_out(data_out), .wr_strobe(wr_strobe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rd;
    logic        err;
    logic [2:0]  ctrl;
    logic [15:0] data;
    logic [1:0]  strb;
    logic        irq;
    int          issue;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready=1 with nothing pending, expected ready=0");
      end else begin
        e = sb.pop_front();
        chk({e.name, "/latency"}, cyc, e.issue + 1);
        chk({e.name, "/rdata"}, rdata, e.rd);
        chk({e.name, "/err"}, err, e.err);
        chk({e.name, "/ctrl_out"}, ctrl_out, e.ctrl);
        chk({e.name, "/data_out"}, data_out, e.data);
        chk({e.name, "/wr_strobe"}, wr_strobe, e.strb);
        chk({e.name, "/irq"}, irq, e.irq);
        $display("txn %-14s rdata=%h err=%b ctrl=%b data=%h strb=%b irq=%b",
                 e.name, rdata, err, ctrl_out, data_out, wr_strobe, irq);
      end
    end
  end

  task automatic drain_chk(input string nm);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s/no_ready: got %0d responses missing, expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic txn(input string nm, input logic w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] e_rd, input logic e_err, input logic [2:0] e_ctrl,
                     input logic [15:0] e_data, input logic [1:0] e_strb, input logic e_irq,
                     input bit pulse0);
    exp_t e;
    @(negedge clk);
    e = '{e_rd, e_err, e_ctrl, e_data, e_strb, e_irq, cyc, nm};
    sb.push_back(e);
    valid = 1'b1; write = w; addr = a; wdata = d;
    if (pulse0) status_in[0] = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    if (pulse0) status_in[0] = 1'b0;
    @(negedge clk);
    #1;
    drain_chk(nm);
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "/ready"}, ready, 1'b0);
    chk({nm, "/err"}, err, 1'b0);
    chk({nm, "/rdata"}, rdata, 8'h00);
    chk({nm, "/ctrl_out"}, ctrl_out, 3'b000);
    chk({nm, "/data_out"}, data_out, 16'h0000);
    chk({nm, "/wr_strobe"}, wr_strobe, 2'b00);
    chk({nm, "/irq"}, irq, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("reset");
    rst_n = 1'b1;

    txn("rd_ctrl0",  1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b0, 1'b0);
    txn("wr_ctrl",   1'b1, 8'h10, 8'hFF, 8'h00, 1'b0, 3'b111, 16'h0000, 2'b00, 1'b0, 1'b0);
    status_in = 5'b10101;
    @(negedge clk);
    txn("rd_ctrl_st", 1'b0, 8'h10, 8'h00, 8'hAF, 1'b0, 3'b111, 16'h0000, 2'b00, STICKY, 1'b0);
    status_in = 5'b00000;

    txn("wr_d0",  1'b1, 8'h11, 8'hA5, 8'h00, 1'b0, 3'b111, 16'h00A5, 2'b01, STICKY, 1'b0);
    txn("wr_d1",  1'b1, 8'h12, 8'h3C, 8'h00, 1'b0, 3'b111, 16'h3CA5, 2'b10, STICKY, 1'b0);
    txn("rd_d0",  1'b0, 8'h11, 8'h00, 8'hA5, 1'b0, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);
    txn("rd_d1",  1'b0, 8'h12, 8'h00, 8'h3C, 1'b0, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);
    txn("rd_13",  1'b0, 8'h13, 8'h00, 8'h00, 1'b1, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);
    txn("wr_13",  1'b1, 8'h13, 8'h55, 8'h00, 1'b1, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);
    txn("rd_0f",  1'b0, 8'h0F, 8'h00, 8'h00, 1'b1, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);
    txn("wr_0f",  1'b1, 8'h0F, 8'h00, 8'h00, 1'b1, 3'b111, 16'h3CA5, 2'b00, STICKY, 1'b0);

    // valid held for 6 cycles: commits every other edge, three responses.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e = '{8'hA5, 1'b0, 3'b111, 16'h3CA5, 2'b00, STICKY, cyc + 2*k, "b2b_rd_d0"};
      sb.push_back(e);
    end
    valid = 1'b1; write = 1'b0; addr = 8'h11;
    repeat (6) @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    #1;
    drain_chk("b2b");

    // Reset asserted inside RESP of a write to data register 0.
    @(negedge clk);
    valid = 1'b1; write = 1'b1; addr = 8'h11; wdata = 8'h77;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    idle_chk("rst_in_resp");
    @(negedge clk);
    rst_n = 1'b1;
    txn("rd_d0_post_rst", 1'b0, 8'h11, 8'h00, 8'h00, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b0, 1'b0);

`ifdef BSG_REG_BANK_STICKY_EN
    @(negedge clk);
    status_in = 5'b00001;
    @(negedge clk);
    status_in = 5'b00000;
    txn("st_rd_set",   1'b0, 8'h10, 8'h00, 8'h08, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b1, 1'b0);
    txn("st_w1c",      1'b1, 8'h10, 8'h08, 8'h00, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b0, 1'b0);
    txn("st_rd_clr",   1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b0, 1'b0);
    txn("st_w1c_coin", 1'b1, 8'h10, 8'h08, 8'h00, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b1, 1'b1);
    txn("st_rd_coin",  1'b0, 8'h10, 8'h00, 8'h08, 1'b0, 3'b000, 16'h0000, 2'b00, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_reg_bank.md
Name: bsg_reg_bank

Overview:
- Parametrised register bank on a valid/ready request bus.
- One control register at BASE_ADDR, split into a low read/write field and a high read-only status field.
- NUM_DATA read/write data registers follow at consecutive addresses.
- Sits between the bus master and the BSG datapath. Adds readback, unmapped-address error signalling and a fixed-latency handshake FSM.

Parameters:
- DATA_W, 8, width of every register and of wdata/rdata.
- ADDR_W, 8, width of addr.
- NUM_DATA, 2, number of data registers (1..16).
- BASE_ADDR, 8'h10, address of the control register; data register i is at BASE_ADDR+1+i.
- CTRL_RW_BITS, 3, number of read/write control bits [CTRL_RW_BITS-1:0]; the remaining bits are read-only status.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  request present; master holds addr/write/wdata stable while valid is high and ready is low.
- write  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  register address.
- wdata  in  DATA_W  write data.
- ready  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ready is high.
- err  out  1  unmapped address; valid while ready is high.
- status_in  in  DATA_W-CTRL_RW_BITS  status bits from the datapath.
- ctrl_out  out  CTRL_RW_BITS  current control field.
- data_out  out  NUM_DATA*DATA_W  data registers; register i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  NUM_DATA  one-cycle pulse when data register i is written.
- irq  out  1  interrupt; see Optional Feature.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - FSM goes to IDLE.
  - ready, err, rdata, ctrl_out, data_out, wr_strobe, irq and the status sample register all go to 0.
  - Any in-flight transaction is dropped with no register update.
- FSM states: IDLE, RESP.
- IDLE:
  - If valid is sampled high at an edge: decode addr, commit the access at that same edge, go to RESP.
  - Otherwise stay in IDLE.
- RESP:
  - ready = 1 for exactly this cycle; err and rdata are driven from registers loaded on entry.
  - Next edge always returns to IDLE.
- Latency: ready rises one cycle after valid is first sampled. A back-to-back request (valid still high in IDLE) starts a new transaction, giving a sustained throughput of 1 transaction per 2 cycles.
- Write commit:
  - Register contents become visible on ctrl_out/data_out in the cycle ready is high.
  - wr_strobe[i] is high in that same cycle only.
- Address decode:
  - addr == BASE_ADDR selects the control register.
  - BASE_ADDR+1 .. BASE_ADDR+NUM_DATA selects data registers.
  - Any other address sets err=1 and rdata=0, and no register changes.
  - Address arithmetic is ADDR_W bits with no wrap: a BASE_ADDR+NUM_DATA that overflows ADDR_W is a configuration error and is flagged at elaboration.
- Control write: only bits [CTRL_RW_BITS-1:0] are written; the read-only bits of wdata are ignored (apart from W1C in the optional feature).
- Control read: rdata = {status_reg, ctrl}. status_reg is status_in registered every clock (one-cycle sample).
- Data read returns the stored value; a read has no side effects.
- If valid drops during RESP, the transaction still completes and ready still pulses. The master must not change the request while waiting; this is not checked.
- Reset asserted during RESP: ready drops immediately and the committed write stays lost, since all registers return to 0.

Optional Feature:
- Macro: BSG_REG_BANK_STICKY_EN.
- Defined:
  - Each status bit becomes sticky: it sets when the status_in bit is high at an edge.
  - Writing 1 to that bit at the control address clears it (W1C).
  - If set and clear occur in the same cycle, set wins.
  - irq = OR of all sticky bits, registered.
- Undefined:
  - The status field is the live one-cycle sample; W1C writes have no effect.
  - irq is tied to 0.

Test Plan:
- Reset then read 8'h10 with status_in=5'b00000 -> ready one cycle after valid, rdata=8'h00, err=0.
- Write 8'h10 data 8'hFF, then read back with status_in=5'b10101 -> ctrl_out=3'b111, rdata=8'hAF.
- Write 8'h11=8'hA5 and 8'h12=8'h3C -> wr_strobe=2'b01 then 2'b10 (one cycle each), data_out=16'h3CA5, reads return 8'hA5 and 8'h3C.
- Read and write 8'h13 and 8'h0F -> err=1 with ready, rdata=8'h00, data_out and ctrl_out unchanged.
- Hold valid high for 6 cycles on reads of 8'h11 -> exactly 3 ready pulses on alternate cycles; pull rst_n low in a RESP cycle -> ready=0 immediately, data_out=0.
- With BSG_REG_BANK_STICKY_EN: pulse status_in[0] for 1 cycle -> read gives bit3=1, irq=1; write 8'h08 -> bit cleared, irq=0; clear coincident with a new pulse -> bit stays 1.
